// File: rtl/ahb_slave_mem_ws.sv
`timescale 1ns/1ps
// AHB-Lite memory slave model: programmable wait states, sized byte-lane
// accesses, pipelined/SEQ transfers and a two-cycle ERROR response.
module ahb_slave_mem_ws #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int DP       = 64,
    parameter int WAIT_CYC = 0,
    parameter bit ERR_EN   = 1'b1
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic [2:0]    hsize,
    input  logic          hwrite,
    input  logic [DW-1:0] hwdata,
    input  logic          hready_i,
    output logic          hready_o,
    output logic          hresp,
    output logic [DW-1:0] hrdata
);
    localparam int NB = DW / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = (DP > 1) ? $clog2(DP) : 1;
    localparam int CW = 4;
    localparam bit ZW = (WAIT_CYC == 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    function automatic logic f_illegal(input logic [AW-1:0] a, input logic [2:0] sz);
        logic [AW-1:0] amask;
        amask = (AW'(1) << sz) - AW'(1);
        return ((a >> LB) >= AW'(DP)) || (int'(sz) > LB) || ((a & amask) != '0);
    endfunction

    function automatic logic [NB-1:0] f_lane_mask(input logic [LB-1:0] off, input logic [2:0] sz);
        logic [NB-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++)
            if (i >= int'(off) && i < int'(off) + (1 << sz)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                              input logic [NB-1:0] m);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++)
            if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    state_t          r_state;
    logic            r_hready;
    logic            r_hresp;
    logic [DW-1:0]   r_hrdata;
    logic            r_dp;
    logic            r_ign;
    logic            r_write;
    logic [IW-1:0]   r_idx;
    logic [LB-1:0]   r_off;
    logic [2:0]      r_size;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_mem [DP];

    logic            w_accept;
    logic            w_bad;
    logic            w_commit;
    logic [NB-1:0]   w_wmask;
    logic [IW-1:0]   w_new_idx;
    logic [IW-1:0]   w_rd_idx;
    logic            w_rd_load;
    logic [DW-1:0]   w_rd_old;
    logic [DW-1:0]   w_rd_data;

    // New address phases are only taken while this slave is not stretching.
    assign w_accept  = hsel & hready_i & htrans[1] & r_hready;
    assign w_bad     = f_illegal(haddr, hsize);
    assign w_commit  = r_dp & r_hready & r_write & ~r_ign;
    assign w_wmask   = f_lane_mask(r_off, r_size);
    assign w_new_idx = haddr[LB +: IW];

    // With zero wait states the read is fetched at the accept edge, which can
    // coincide with a write commit to the same word, hence the merge bypass.
    assign w_rd_idx  = ZW ? w_new_idx : r_idx;
    assign w_rd_load = ZW ? (w_accept & ~hwrite & ~w_bad)
                          : ((r_state == S_WAIT) & (r_cnt == CW'(1)) & r_dp & ~r_write & ~r_ign);
    assign w_rd_old  = r_mem[w_rd_idx];
    assign w_rd_data = (w_commit && (r_idx == w_rd_idx)) ? f_merge(w_rd_old, hwdata, w_wmask) : w_rd_old;

    assign hready_o = r_hready;
    assign hresp    = r_hresp;
    assign hrdata   = r_hrdata;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state  <= S_IDLE;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
            r_hrdata <= '0;
            r_dp     <= 1'b0;
            r_ign    <= 1'b0;
            r_write  <= 1'b0;
            r_idx    <= '0;
            r_off    <= '0;
            r_size   <= '0;
            r_cnt    <= '0;
        end else begin
            r_hrdata <= '0;
            if (w_rd_load) r_hrdata <= w_rd_data;
            case (r_state)
                S_IDLE, S_ERR2: begin
                    r_state  <= S_IDLE;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b0;
                    r_dp     <= 1'b0;
                    if (w_accept) begin
                        r_idx   <= w_new_idx;
                        r_off   <= haddr[LB-1:0];
                        r_size  <= hsize;
                        r_write <= hwrite;
                        if (ERR_EN && w_bad) begin
                            r_state  <= S_ERR1;
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b1;
                        end else begin
                            r_dp  <= 1'b1;
                            r_ign <= w_bad;
                            if (!ZW) begin
                                r_state  <= S_WAIT;
                                r_hready <= 1'b0;
                                r_cnt    <= CW'(WAIT_CYC);
                            end
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state  <= S_IDLE;
                        r_hready <= 1'b1;
                    end
                end
                S_ERR1: begin
                    r_state  <= S_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < DP; i++) r_mem[i] <= '0;
        end else if (w_commit) begin
            r_mem[r_idx] <= f_merge(r_mem[r_idx], hwdata, w_wmask);
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem_ws.sv
`timescale 1ns/1ps
// Bench for ahb_slave_mem_ws: three instances (0/2/3 wait states, the last with
// ERROR responses disabled) driven by a pipelined bus driver and a byte-level model.
module tb_ahb_slave_mem_ws;

    typedef struct {
        bit          sel;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic [1:0]  trans;
    } xfer_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       hsel = '0, hwrite = '0, hready_o, hresp;
    logic [2:0][31:0] haddr = '0, hwdata = '0, hrdata;
    logic [2:0][1:0]  htrans = '0;
    logic [2:0][2:0]  hsize = '0;

    logic [7:0] mb [3][256];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ahb_slave_mem_ws #(.DW(32), .AW(32), .DP(64), .WAIT_CYC(0), .ERR_EN(1'b1)) u_a (
        .hclk(clk), .hreset(rst), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]),
        .hsize(hsize[0]), .hwrite(hwrite[0]), .hwdata(hwdata[0]), .hready_i(hready_o[0]),
        .hready_o(hready_o[0]), .hresp(hresp[0]), .hrdata(hrdata[0]));
    ahb_slave_mem_ws #(.DW(32), .AW(32), .DP(64), .WAIT_CYC(2), .ERR_EN(1'b1)) u_b (
        .hclk(clk), .hreset(rst), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]),
        .hsize(hsize[1]), .hwrite(hwrite[1]), .hwdata(hwdata[1]), .hready_i(hready_o[1]),
        .hready_o(hready_o[1]), .hresp(hresp[1]), .hrdata(hrdata[1]));
    ahb_slave_mem_ws #(.DW(32), .AW(32), .DP(64), .WAIT_CYC(3), .ERR_EN(1'b0)) u_c (
        .hclk(clk), .hreset(rst), .hsel(hsel[2]), .haddr(haddr[2]), .htrans(htrans[2]),
        .hsize(hsize[2]), .hwrite(hwrite[2]), .hwdata(hwdata[2]), .hready_i(hready_o[2]),
        .hready_o(hready_o[2]), .hresp(hresp[2]), .hrdata(hrdata[2]));

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 3;
    endfunction

    function automatic bit err_of(input int k);
        return k != 2;
    endfunction

    function automatic xfer_t mk(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                                 input logic [31:0] d, input logic [1:0] tr);
        xfer_t x;
        x.sel = 1'b1; x.wr = wr; x.addr = a; x.size = sz; x.data = d; x.trans = tr;
        return x;
    endfunction

    // 256-byte memory: anything at or beyond it, wider than a word, or not
    // aligned to its own size is illegal.
    function automatic bit illegal(input xfer_t x);
        if (x.size > 3'd2) return 1'b1;
        if (x.addr >= 32'd256) return 1'b1;
        return (x.addr % (32'd1 << x.size)) != 32'd0;
    endfunction

    function automatic logic [31:0] model_read(input int k, input logic [31:0] a);
        int base;
        base = int'(a & 32'hFC);
        return {mb[k][base+3], mb[k][base+2], mb[k][base+1], mb[k][base]};
    endfunction

    task automatic model_write(input int k, input xfer_t x);
        int a;
        for (int b = 0; b < (1 << x.size); b++) begin
            a = int'(x.addr) + b;
            mb[k][a] = x.data[8*(a%4) +: 8];
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 256; i++) mb[k][i] = 8'h00;
    endtask

    task automatic drive_addr(input int k, input xfer_t q[$], input int ap);
        if (ap < q.size()) begin
            hsel[k] = q[ap].sel; haddr[k] = q[ap].addr; htrans[k] = q[ap].trans;
            hsize[k] = q[ap].size; hwrite[k] = q[ap].wr;
        end else begin
            hsel[k] = 1'b0; haddr[k] = '0; htrans[k] = 2'b00; hsize[k] = '0; hwrite[k] = 1'b0;
        end
    endtask

    // Runs a pipelined transfer list on DUT k and checks every data-phase cycle.
    task automatic run_xfers(input int k, input xfer_t q[$], input string nm, output int dcyc);
        int ap, dp, c, w;
        bit act, err, rdy;
        logic e_rdy, e_resp;
        logic [31:0] e_data;
        w = wait_of(k);
        ap = 0; dp = -1; c = 0; dcyc = 0;
        drive_addr(k, q, ap);
        hwdata[k] = $urandom;
        for (int g = 0; g < 4000; g++) begin
            act = (dp >= 0) && (dp < q.size()) && q[dp].sel && q[dp].trans[1];
            err = act && err_of(k) && illegal(q[dp]);
            e_rdy = 1'b1; e_resp = 1'b0; e_data = '0;
            if (err) begin
                e_rdy = (c == 1); e_resp = 1'b1;
            end else if (act) begin
                e_rdy = (c == w);
                if (c == w && !q[dp].wr && !illegal(q[dp])) e_data = model_read(k, q[dp].addr);
            end
            @(negedge clk);
            if (act) dcyc++;
            total += 3;
            if (hready_o[k] !== e_rdy) begin
                bad++; $display("FAIL %s k=%0d xfer=%0d hready_o got=%b exp=%b", nm, k, dp, hready_o[k], e_rdy);
            end
            if (hresp[k] !== e_resp) begin
                bad++; $display("FAIL %s k=%0d xfer=%0d hresp got=%b exp=%b", nm, k, dp, hresp[k], e_resp);
            end
            if (hrdata[k] !== e_data) begin
                bad++; $display("FAIL %s k=%0d xfer=%0d hrdata got=%h exp=%h", nm, k, dp, hrdata[k], e_data);
            end
            rdy = (hready_o[k] === 1'b1);
            @(posedge clk);
            if (rdy) begin
                if (act && !err && q[dp].wr && !illegal(q[dp])) model_write(k, q[dp]);
                dp = ap; ap++; c = 0;
            end else begin
                c++;
                if (c > w + 2) begin
                    total++; bad++;
                    $display("FAIL %s k=%0d xfer=%0d timeout stuck=%0d limit=%0d", nm, k, dp, c, w + 2);
                    #1; drive_addr(k, q, q.size());
                    break;
                end
            end
            #1;
            drive_addr(k, q, ap);
            if (dp >= 0 && dp < q.size() && q[dp].wr)
                hwdata[k] = (c == w) ? q[dp].data : $urandom;
            else
                hwdata[k] = $urandom;
            if (dp >= q.size()) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            total += 3;
            if (hready_o[k] !== 1'b1) begin bad++; $display("FAIL reset_hready k=%0d got=%b exp=1", k, hready_o[k]); end
            if (hresp[k] !== 1'b0) begin bad++; $display("FAIL reset_hresp k=%0d got=%b exp=0", k, hresp[k]); end
            if (hrdata[k] !== 32'h0) begin bad++; $display("FAIL reset_hrdata k=%0d got=%h exp=0", k, hrdata[k]); end
        end
        model_clear();
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        xfer_t q[$];
        int dc;
        q.push_back(mk(1, 32'h10, 3'd2, 32'hDEADBEEF, 2'b10));
        q.push_back(mk(0, 32'h10, 3'd2, 32'h0, 2'b10));
        run_xfers(0, q, "basic", dc);
        run_xfers(1, q, "basic_ws", dc);
    endtask

    task automatic test_wait_burst();
        xfer_t q[$];
        int dc;
        q.push_back(mk(0, 32'h10, 3'd2, 32'h0, 2'b10));
        run_xfers(1, q, "ws_read", dc);
        q.delete();
        for (int i = 0; i < 4; i++)
            q.push_back(mk(1, 32'(4*i), 3'd2, $urandom, (i == 0) ? 2'b10 : 2'b11));
        run_xfers(1, q, "burst_wr", dc);
        total++;
        if (dc !== 4 * (wait_of(1) + 1)) begin
            bad++; $display("FAIL burst_cycles got=%0d exp=%0d", dc, 4 * (wait_of(1) + 1));
        end
        q.delete();
        for (int i = 0; i < 4; i++)
            q.push_back(mk(0, 32'(4*i), 3'd2, 32'h0, (i == 0) ? 2'b10 : 2'b11));
        run_xfers(1, q, "burst_rd", dc);
    endtask

    task automatic test_lanes(input int k);
        xfer_t q[$];
        int dc;
        q.push_back(mk(1, 32'h20, 3'd2, 32'h11223344, 2'b10));
        q.push_back(mk(1, 32'h21, 3'd0, ($urandom & 32'hFFFF00FF) | 32'h0000AA00, 2'b10));
        q.push_back(mk(0, 32'h20, 3'd2, 32'h0, 2'b10));
        q.push_back(mk(1, 32'h22, 3'd1, ($urandom & 32'h0000FFFF) | 32'h55660000, 2'b10));
        q.push_back(mk(0, 32'h20, 3'd2, 32'h0, 2'b10));
        q.push_back(mk(0, 32'h23, 3'd0, 32'h0, 2'b10));
        run_xfers(k, q, "lanes", dc);
    endtask

    task automatic test_error(input int k);
        xfer_t q[$];
        int dc;
        q.push_back(mk(1, 32'h100, 3'd2, $urandom, 2'b10));
        q.push_back(mk(0, 32'h0, 3'd2, 32'h0, 2'b10));
        q.push_back(mk(1, 32'h1, 3'd1, $urandom, 2'b10));
        q.push_back(mk(1, 32'h0, 3'd3, $urandom, 2'b10));
        q.push_back(mk(0, 32'h100, 3'd2, 32'h0, 2'b10));
        q.push_back(mk(0, 32'h0, 3'd2, 32'h0, 2'b10));
        run_xfers(k, q, "error", dc);
    endtask

    task automatic test_bypass(input int k);
        xfer_t q[$];
        int dc;
        q.push_back(mk(1, 32'h8, 3'd2, 32'hCAFEF00D, 2'b10));
        q.push_back(mk(0, 32'h8, 3'd2, 32'h0, 2'b10));
        q.push_back(mk(1, 32'h9, 3'd0, $urandom, 2'b10));
        q.push_back(mk(0, 32'h8, 3'd2, 32'h0, 2'b10));
        run_xfers(k, q, "bypass", dc);
    endtask

    task automatic test_err_disabled();
        xfer_t q[$];
        int dc;
        q.push_back(mk(1, 32'h4, 3'd2, 32'hA5A5_5A5A, 2'b10));
        q.push_back(mk(1, 32'h100, 3'd2, $urandom, 2'b10));
        q.push_back(mk(0, 32'h100, 3'd2, 32'h0, 2'b10));
        q.push_back(mk(1, 32'h5, 3'd1, $urandom, 2'b10));
        q.push_back(mk(0, 32'h4, 3'd2, 32'h0, 2'b10));
        run_xfers(2, q, "errdis", dc);
    endtask

    task automatic test_random(input int k);
        xfer_t q[$];
        xfer_t x;
        int r, dc;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            x.sel = 1'b1; x.trans = 2'b10; x.wr = 1'($urandom_range(0, 1)); x.data = $urandom;
            x.size = 3'($urandom_range(0, 2));
            x.addr = 32'($urandom_range(0, 255)) & ~((32'd1 << x.size) - 32'd1);
            if (r == 0) x.trans = 2'b00;
            else if (r == 1) x.trans = 2'b01;
            else if (r == 2) x.sel = 1'b0;
            else if (r == 3) x.addr = 32'($urandom_range(0, 511));
            else if (r == 4) x.size = 3'($urandom_range(3, 7));
            else if (r >= 7) x.trans = 2'b11;
            q.push_back(x);
        end
        run_xfers(k, q, "random", dc);
    endtask

    task automatic test_reset_mid();
        xfer_t q[$];
        int dc;
        hsel[2] = 1'b1; haddr[2] = 32'h30; htrans[2] = 2'b10; hsize[2] = 3'd2; hwrite[2] = 1'b1;
        @(posedge clk); #1;
        hsel[2] = 1'b0; htrans[2] = 2'b00; hwdata[2] = 32'h12345678;
        @(posedge clk); #3;
        total++;
        if (hready_o[2] !== 1'b0) begin bad++; $display("FAIL rstmid_wait hready_o got=%b exp=0", hready_o[2]); end
        rst = 1'b1;
        #1;
        total += 3;
        if (hready_o[2] !== 1'b1) begin bad++; $display("FAIL rstmid_hready got=%b exp=1", hready_o[2]); end
        if (hresp[2] !== 1'b0) begin bad++; $display("FAIL rstmid_hresp got=%b exp=0", hresp[2]); end
        if (hrdata[2] !== 32'h0) begin bad++; $display("FAIL rstmid_hrdata got=%h exp=0", hrdata[2]); end
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        q.push_back(mk(0, 32'h30, 3'd2, 32'h0, 2'b10));
        run_xfers(2, q, "rstmid_read", dc);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_wait_burst();
        test_lanes(0);
        test_lanes(1);
        test_error(0);
        test_error(1);
        test_bypass(0);
        test_bypass(1);
        test_err_disabled();
        for (int k = 0; k < 3; k++) test_random(k);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
